// File: rtl/imm_encoder_pkg.sv
// Shared encodings for the immediate encoder: format selectors, error codes
// and the stage-1 request record.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_SEL   = 2'd3;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [1:0]  err;
  } req_t;

  function automatic logic sel_known(input logic [2:0] sel);
    return (sel == IMM_I) || (sel == IMM_S) || (sel == IMM_B) ||
           (sel == IMM_U) || (sel == IMM_J);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle between an encoder client (master) and the encoder (slave).
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;

  modport master (
    output in_valid, in_sel, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder_scatter.sv
// Combinational scatter of an immediate into its instruction-word bit positions;
// bits outside the selected format's immediate field pass through from base.
module imm_encoder_scatter
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] inst
);

  always_comb begin
    inst = base;
    case (sel)
      IMM_I: inst[31:20] = imm[11:0];
      IMM_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
      end
      IMM_B: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
      end
      IMM_U: inst[31:12] = imm[31:12];
      IMM_J: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 checks range/alignment,
// stage 2 merges the scattered immediate into the template. Keeps ok/error counts.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  req_t             req_p1_q, req_p1_d;
  logic [31:0]      inst_p2_q, inst_p2_d;
  logic [1:0]       err_p2_q, err_p2_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             s2_ready, accept, advance, out_hs;
  logic [31:0]      scat_inst;

  // Priority: bad format, then misalignment, then range.
  function automatic logic [1:0] check_imm(input logic [2:0] sel, input logic signed [31:0] imm);
    logic rng_bad;
    rng_bad = 1'b0;
    case (sel)
      IMM_I, IMM_S: rng_bad = (imm[31:11] != '0) && (imm[31:11] != '1);
      IMM_B:        rng_bad = (imm[31:12] != '0) && (imm[31:12] != '1);
      IMM_J:        rng_bad = (imm[31:20] != '0) && (imm[31:20] != '1);
      IMM_U:        rng_bad = (imm[11:0] != '0);
      default:      rng_bad = 1'b0;
    endcase
    if (!sel_known(sel))                                 return ERR_SEL;
    else if (((sel == IMM_B) || (sel == IMM_J)) && imm[0]) return ERR_ALIGN;
    else if (rng_bad)                                    return ERR_RANGE;
    else                                                 return ERR_OK;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s2_ready     = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = !vld_p1_q || s2_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign advance      = vld_p1_q && s2_ready;
  assign out_hs       = vld_p2_q && bus.out_ready;

  imm_encoder_scatter u_scatter (
    .sel  (req_p1_q.sel),
    .imm  (req_p1_q.imm),
    .base (req_p1_q.base),
    .inst (scat_inst)
  );

  always_comb begin
    // stage 1: capture request and classify it
    vld_p1_d = vld_p1_q;
    req_p1_d = req_p1_q;
    if (accept) begin
      vld_p1_d = 1'b1;
      req_p1_d = '{sel:  bus.in_sel,
                   imm:  bus.in_imm,
                   base: bus.in_base,
                   err:  check_imm(bus.in_sel, $signed(bus.in_imm))};
    end else if (advance) begin
      vld_p1_d = 1'b0;
    end

    // stage 2: merged instruction, or the untouched template on error
    vld_p2_d  = vld_p2_q;
    inst_p2_d = inst_p2_q;
    err_p2_d  = err_p2_q;
    if (s2_ready) begin
      vld_p2_d = vld_p1_q;
      if (advance) begin
        inst_p2_d = (req_p1_q.err == ERR_OK) ? scat_inst : req_p1_q.base;
        err_p2_d  = req_p1_q.err;
      end
    end

    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      ok_cnt_d  = '0;
      err_cnt_d = '0;
    end else if (out_hs) begin
      if (err_p2_q == ERR_OK) ok_cnt_d  = sat_inc(ok_cnt_q);
      else                    err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      inst_p2_q <= '0;
      err_p2_q  <= ERR_OK;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      inst_p2_q <= inst_p2_d;
      err_p2_q  <= err_p2_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    req_p1_q <= req_p1_d;
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.out_inst  = inst_p2_q;
  assign bus.out_err   = err_p2_q;
  assign ok_cnt        = ok_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: packing, error codes, backpressure,
// random round-trip through a reference immgen, counters and async reset.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] ok_cnt, err_cnt;
  logic [3:0]  ok4, err4;
  logic        cnt_clr4 = 1'b0;
  int          checks = 0;
  int          failures = 0;

  imm_encoder_if bus ();
  imm_encoder_if bus4 ();

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .cnt_clr(cnt_clr), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  imm_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .cnt_clr(cnt_clr4), .ok_cnt(ok4), .err_cnt(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decoder (instruction -> immediate).
  function automatic logic [31:0] immgen(input logic [2:0] sel, input logic [31:0] i);
    case (sel)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] exp_err(input logic [2:0] sel, input logic [31:0] imm);
    logic signed [31:0] s;
    s = imm;
    if (sel > 3'd4) return 2'd3;
    if (((sel == IMM_B) || (sel == IMM_J)) && imm[0]) return 2'd2;
    case (sel)
      IMM_I, IMM_S: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
      IMM_B:        return (s < -4096 || s > 4095) ? 2'd1 : 2'd0;
      IMM_J:        return (s < -1048576 || s > 1048575) ? 2'd1 : 2'd0;
      default:      return (imm[11:0] != 12'h0) ? 2'd1 : 2'd0;
    endcase
  endfunction

  // One request with out_ready high; checks the two-cycle latency.
  task automatic xfer(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                      input logic [31:0] base, output logic [31:0] inst, output logic [1:0] err);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_sel = sel; bus.in_imm = imm; bus.in_base = base;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    inst = bus.out_inst;
    err  = bus.out_err;
  endtask

  logic [31:0] inst, imm, base;
  logic [1:0]  err;
  logic [2:0]  sel;
  logic [31:0] r;
  logic [15:0] pat;
  logic        hold_v;
  logic [31:0] hold_inst;
  int          sent, got, inflight;

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_imm = '0; bus.in_base = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_sel = IMM_I; bus4.in_imm = '0; bus4.in_base = 32'h13;
    bus4.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Field packing
    xfer("pk_i", IMM_I, 32'hFFFFFFFF, 32'h00000013, inst, err);
    chk("pk_i_inst", inst, 32'hFFF00013); chk("pk_i_err", 32'(err), 32'd0);
    xfer("pk_s", IMM_S, 32'h000007FF, 32'h00002023, inst, err);
    chk("pk_s_inst", inst, 32'h7E002FA3); chk("pk_s_err", 32'(err), 32'd0);
    xfer("pk_b", IMM_B, 32'hFFFFFFFC, 32'h00000063, inst, err);
    chk("pk_b_inst", inst, 32'hFE000EE3); chk("pk_b_err", 32'(err), 32'd0);
    xfer("pk_j", IMM_J, 32'h00000800, 32'h0000006F, inst, err);
    chk("pk_j_inst", inst, 32'h0010006F); chk("pk_j_err", 32'(err), 32'd0);
    xfer("pk_u", IMM_U, 32'h12345000, 32'h00000037, inst, err);
    chk("pk_u_inst", inst, 32'h12345037); chk("pk_u_err", 32'(err), 32'd0);

    // Errors
    xfer("er_i", IMM_I, 32'h00000800, 32'h00000013, inst, err);
    chk("er_i_err", 32'(err), 32'd1); chk("er_i_inst", inst, 32'h00000013);
    xfer("er_b", IMM_B, 32'h00000003, 32'hFFFFFFFF, inst, err);
    chk("er_b_err", 32'(err), 32'd2); chk("er_b_inst", inst, 32'hFFFFFFFF);
    xfer("er_u", IMM_U, 32'h00000001, 32'h00000037, inst, err);
    chk("er_u_err", 32'(err), 32'd1); chk("er_u_inst", inst, 32'h00000037);
    xfer("er_sel", 3'd6, 32'h00000000, 32'hA5A5A5A5, inst, err);
    chk("er_sel_err", 32'(err), 32'd3); chk("er_sel_inst", inst, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("cnt_ok_5", 32'(ok_cnt), 32'd5);
    chk("cnt_err_4", 32'(err_cnt), 32'd4);

    // Backpressure: 10 back-to-back requests, fixed pseudo-random out_ready
    sent = 0; got = 0; inflight = 0; hold_v = 1'b0; hold_inst = '0; pat = 16'hB38D;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(posedge clk); #1;
      bus.in_valid = (sent < 10);
      bus.in_sel = IMM_I; bus.in_imm = 32'(sent + 1); bus.in_base = 32'h00000013;
      bus.out_ready = pat[cyc % 16];
      @(negedge clk);
      if (hold_v) begin
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_inst", bus.out_inst, hold_inst);
      end
      chk("bp_in_ready", 32'(bus.in_ready), 32'((inflight < 2) || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_data", bus.out_inst, 32'(((got + 1) << 20) | 32'h13));
        got++; inflight--;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_inst = bus.out_inst;
      if (bus.in_valid && bus.in_ready) begin sent++; inflight++; end
    end
    chk("bp_delivered", 32'(got), 32'd10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp_ok_cnt", 32'(ok_cnt), 32'd15);
    chk("bp_err_cnt", 32'(err_cnt), 32'd4);

    // cnt_clr beats a same-cycle handshake
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_sel = IMM_I; bus.in_imm = 32'd5; bus.in_base = 32'h13;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_hs_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_ok_cnt", 32'(ok_cnt), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Random round-trip through the reference decoder
    for (int n = 0; n < 1000; n++) begin
      sel = 3'($urandom_range(0, 7));
      r = $urandom;
      imm = 32'($signed(r) >>> $urandom_range(8, 31));
      if ($urandom_range(0, 3) == 0) imm[11:0] = 12'h0;
      if ($urandom_range(0, 1) == 0) imm[0] = 1'b0;
      base = $urandom;
      xfer("rt", sel, imm, base, inst, err);
      chk("rt_err", 32'(err), 32'(exp_err(sel, imm)));
      if (err == 2'd0) chk("rt_imm", immgen(sel, inst), imm);
      else             chk("rt_base", inst, base);
    end

    // Saturation on the 4-bit counter build
    @(posedge clk); #1;
    bus4.in_valid = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    chk("sat_ok4", 32'(ok4), 32'd15);
    chk("sat_err4", 32'(err4), 32'd0);

    // Async reset with both stages full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = IMM_I; bus.in_imm = 32'd1; bus.in_base = 32'h13;
    @(posedge clk); #1;
    bus.in_imm = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ok_cnt", 32'(ok_cnt), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    xfer("post_rst", IMM_I, 32'h00000123, 32'h00000013, inst, err);
    chk("post_rst_inst", inst, 32'h12300013);
    chk("post_rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_ok_cnt", 32'(ok_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
